// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file with byte-strobe writes, per-register commit pulses and RO status slots.
// Define AXI_LITE_REGFILE_ERR_RESP_EN to return SLVERR for out-of-range accesses and RO writes.
module axi_lite_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int ADDR_LSB = (DATA_WIDTH == 64) ? 3 : 2;
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t r_wstate;
    r_state_t r_rstate;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;
    logic                  r_aw_got, r_w_got;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic                  r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]            r_bresp, r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [NUM_REGS-1:0]   r_wr_pulse;

    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdat;
    logic [STRB_W-1:0]     w_wstb;
    logic [NUM_REGS-1:0]   w_wsel, w_rsel;
    logic [DATA_WIDTH-1:0] w_rdat;
    logic                  w_winr, w_wro, w_wok, w_rinr;
    logic [1:0]            w_bresp, w_rresp;
    logic                  w_unused;

    assign w_aw_hs  = awvalid & r_awready;
    assign w_w_hs   = wvalid & r_wready;
    assign w_ar_hs  = arvalid & r_arready;
    // The last handshake commits in the same edge, so use the live channel when it is the one arriving
    assign w_waddr  = w_aw_hs ? awaddr : r_awaddr;
    assign w_wdat   = w_w_hs ? wdata : r_wdata;
    assign w_wstb   = w_w_hs ? wstrb : r_wstrb;
    assign w_commit = (r_wstate == W_IDLE) && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);

    always_comb begin
        w_wsel = '0;
        w_rsel = '0;
        w_rdat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_waddr[ADDR_WIDTH-1:ADDR_LSB] == IDX_W'(i)) w_wsel[i] = 1'b1;
            if (araddr[ADDR_WIDTH-1:ADDR_LSB] == IDX_W'(i)) begin
                w_rsel[i] = 1'b1;
                w_rdat    = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
            end
        end
    end

    assign w_winr = |w_wsel;
    assign w_wro  = |(w_wsel & RO_MASK);
    assign w_wok  = w_winr & ~w_wro;
    assign w_rinr = |w_rsel;

`ifdef AXI_LITE_REGFILE_ERR_RESP_EN
    assign w_bresp = w_wok ? 2'b00 : 2'b10;
    assign w_rresp = w_rinr ? 2'b00 : 2'b10;
`else
    assign w_bresp = 2'b00;
    assign w_rresp = 2'b00;
`endif

    assign w_unused = ^{awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0], reg_in, w_rinr};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate   <= W_IDLE;
            r_regs     <= '0;
            r_aw_got   <= 1'b0;
            r_w_got    <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_got <= 1'b1;
                        r_awaddr <= awaddr;
                    end
                    if (w_w_hs) begin
                        r_w_got <= 1'b1;
                        r_wdata <= wdata;
                        r_wstrb <= wstrb;
                    end
                    if (w_commit) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (w_wok && w_wsel[i]) begin
                                for (int b = 0; b < STRB_W; b++) begin
                                    if (w_wstb[b]) r_regs[i][b*8 +: 8] <= w_wdat[b*8 +: 8];
                                end
                            end
                        end
                        r_wr_pulse <= w_wok ? w_wsel : '0;
                        r_bvalid   <= 1'b1;
                        r_bresp    <= w_bresp;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b0;
                        r_aw_got   <= 1'b0;
                        r_w_got    <= 1'b0;
                        r_wstate   <= W_RESP;
                    end else begin
                        r_awready <= ~(r_aw_got | w_aw_hs);
                        r_wready  <= ~(r_w_got | w_w_hs);
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_rdata   <= w_rdat;
                        r_rresp   <= w_rresp;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign awready  = r_awready;
    assign wready   = r_wready;
    assign bvalid   = r_bvalid;
    assign bresp    = r_bresp;
    assign arready  = r_arready;
    assign rvalid   = r_rvalid;
    assign rdata    = r_rdata;
    assign rresp    = r_rresp;
    assign reg_out  = r_regs;
    assign wr_pulse = r_wr_pulse;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Randomized self-checking bench for axi_lite_regfile against an array-based register model.
// Response expectations follow AXI_LITE_REGFILE_ERR_RESP_EN as compiled.
module tb_axi_lite_regfile;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO = 16'h0008;
`ifdef AXI_LITE_REGFILE_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;
    logic [31:0] rdata;
    logic [NR*32-1:0] reg_out;
    logic [NR*32-1:0] reg_in = '0;
    logic [NR-1:0] wr_pulse;

    int n_total = 0;
    int n_bad = 0;
    logic [31:0] mdl [NR];

    axi_lite_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .RO_MASK(RO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [511:0] model_out();
        logic [511:0] o;
        o = '0;
        for (int i = 0; i < NR; i++) o[i*32 +: 32] = RO[i] ? 32'h0 : mdl[i];
        return o;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        int idx, cyc;
        bit ok, aw_done, w_done, hs_aw, hs_w;
        logic [NR-1:0] ep;
        logic [1:0] eb;
        idx = int'(addr >> 2);
        ok  = (idx < NR) && !RO[idx];
        ep  = ok ? (NR'(1) << idx) : '0;
        eb  = (!ok && ERR_EN) ? 2'b10 : 2'b00;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 30) begin
            awaddr = addr; wdata = data; wstrb = strb;
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge aclk); #1;
            if (hs_aw) aw_done = 1;
            if (hs_w) w_done = 1;
            if (!(aw_done && w_done)) chk("b_early", bvalid, 0);
            cyc++;
        end
        awvalid = 0; wvalid = 0;
        if (!(aw_done && w_done)) chk("w_timeout", 0, 1);
        if (ok) for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, eb);
        chk("wr_pulse", wr_pulse, ep);
        chk("reg_out", reg_out, model_out());
        chk("wrdy_lo", {awready, wready}, 2'b00);
        for (int k = 0; k < b_dly; k++) begin
            @(posedge aclk); #1;
            chk("bvalid_hold", {bvalid, bresp, awready, wready}, {1'b1, eb, 2'b00});
            chk("pulse_1cyc", wr_pulse, 0);
        end
        bready = 1;
        @(posedge aclk); #1;
        bready = 0;
        chk("b_done", {bvalid, awready, wready}, 3'b011);
        chk("pulse_end", wr_pulse, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold);
        int idx, cyc;
        bit done, hs;
        logic [31:0] ed;
        logic [1:0] er;
        idx = int'(addr >> 2);
        ed  = (idx >= NR) ? 32'h0 : (RO[idx] ? reg_in[idx*32 +: 32] : mdl[idx]);
        er  = (idx >= NR && ERR_EN) ? 2'b10 : 2'b00;
        araddr = addr; arvalid = 1; done = 0; cyc = 0;
        while (!done && cyc < 30) begin
            hs = arready;
            @(posedge aclk); #1;
            if (hs) done = 1;
            cyc++;
        end
        arvalid = 0;
        if (!done) chk("r_timeout", 0, 1);
        chk("rvalid", rvalid, 1);
        chk("rdata", rdata, ed);
        chk("rresp", rresp, er);
        chk("arrdy_lo", arready, 0);
        for (int k = 0; k < hold; k++) begin
            @(posedge aclk); #1;
            chk("r_hold", {rvalid, arready, rresp, rdata}, {1'b1, 1'b0, er, ed});
        end
        rready = 1;
        @(posedge aclk); #1;
        rready = 0;
        chk("r_done", {rvalid, arready}, 2'b01);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        #13;
        chk("rst_out", {bvalid, rvalid, awready, wready, arready, wr_pulse}, 0);
        chk("rst_regs", reg_out, 0);
        chk("rst_resp", {bresp, rresp, rdata}, 0);
        @(negedge aclk); aresetn = 1;
        #1 chk("rdy_pre_edge", {awready, wready, arready}, 3'b000);
        @(posedge aclk); #1;
        chk("rdy_post_edge", {awready, wready, arready}, 3'b111);

        do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_write(32'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 1);
        do_write(32'h8, 32'h12345678, 4'h5, 3, 0, 0);
        chk("strb_merge", reg_out[95:64], 32'hFF34FF78);
        do_read(32'h8, 0);

        reg_in[3*32 +: 32] = 32'hCAFEF00D;
        do_read(32'hC, 4);

        do_write(32'h40, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
        do_write(32'hC, 32'h5A5A5A5A, 4'hF, 1, 0, 0);
        do_read(32'h40, 1);

        do_write(32'h8, 32'h11, 4'hF, 0, 0, 0);
        awaddr = 32'h8; wdata = 32'h22; wstrb = 4'hF; araddr = 32'h8;
        chk("sim_rdy", {awready, wready, arready}, 3'b111);
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        mdl[2] = 32'h22;
        chk("sim_rdata_old", rdata, 32'h11);
        chk("sim_valids", {rvalid, bvalid}, 2'b11);
        chk("sim_reg_new", reg_out[95:64], 32'h22);
        bready = 1; rready = 1;
        @(posedge aclk); #1;
        bready = 0; rready = 0;
        do_read(32'h8, 0);

        awaddr = 32'h14; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0;
        chk("pre_rst_bvalid", bvalid, 1);
        #2 aresetn = 0;
        #1;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        chk("rst_bvalid", {bvalid, awready, wready, arready, wr_pulse}, 0);
        chk("rst_clear", reg_out, model_out());
        @(negedge aclk); aresetn = 1;
        @(posedge aclk); #1;
        chk("rst_rdy", {awready, wready, arready, bvalid}, 4'b1110);
        do_write(32'h14, 32'h99, 4'hF, 0, 1, 0);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 17) << 2) | $urandom_range(0, 3);
            for (int i = 0; i < NR; i++) reg_in[i*32 +: 32] = $urandom;
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2));
        end
        chk("final_regs", reg_out, model_out());

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
